// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor / resolver pair.
package branch_pkg;

  // Word-addressed PC width shared with the tournament predictor.
  localparam int BR_PC_W = 10;

  // Resolver control state.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_t;

  // In-flight prediction record at the default PC width.
  typedef struct packed {
    logic [BR_PC_W-1:0] pc;
    logic               pred;
    logic [BR_PC_W-1:0] target;
  } br_entry_t;

endpackage

// File: rtl/pred_queue.sv
// Small synchronous FIFO with clear; holds Decode predictions until Execute resolves them.
module pred_queue #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty when the low bits match.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage write; a clear in the same cycle discards the push.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointer update; clear collapses the queue to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: checks queued predictions against actual
// outcomes, trains the predictor, and redirects/flushes on a mispredict.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int PC_W         = BR_PC_W,
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  input  logic [PC_W-1:0]  d_pc,
  input  logic             d_pred,
  input  logic [PC_W-1:0]  d_target,
  output logic             d_stall,
  input  logic             e_valid,
  input  logic [PC_W-1:0]  e_pc,
  input  logic             e_taken,
  output logic             update_enable,
  output logic             update_value,
  output logic [PC_W-1:0]  update_pc,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush,
  output logic             seq_error,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             full,
  output logic             empty
);

  // Entry layout matches branch_pkg::br_entry_t, widened to this instance's PC_W.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
    logic [PC_W-1:0] target;
  } entry_t;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_t       state;
  logic [FC_W-1:0] fcnt;
  entry_t          wentry, head;
  logic            idle, push, resolve, pop, miss, pc_mismatch;

  assign idle        = (state == ST_IDLE);
  assign push        = d_valid & ~full & idle;
  assign resolve     = e_valid & idle;
  assign pop         = resolve & ~empty;
  assign pc_mismatch = (head.pc != e_pc);
  assign miss        = pop & (e_taken != head.pred);
  assign d_stall     = d_valid & full;

  assign wentry.pc     = d_pc;
  assign wentry.pred   = d_pred;
  assign wentry.target = d_target;

  pred_queue #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clr   (miss),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Control FSM plus registered resolve outputs (update, redirect, flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      fcnt          <= '0;
      flush         <= 1'b0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      update_enable <= 1'b0;
      update_value  <= 1'b0;
      update_pc     <= '0;
      seq_error     <= 1'b0;
    end else begin
      update_enable <= pop;
      mispredict    <= miss;
      if (pop) begin
        update_value <= e_taken;
        // Equals head.pc on a clean resolve; on a mismatch train the PC Execute reports.
        update_pc    <= e_pc;
      end
      if (resolve && (empty || pc_mismatch)) seq_error <= 1'b1;
      if (miss) redirect_pc <= e_taken ? head.target : head.pc + PC_W'(1);

      case (state)
        ST_IDLE: begin
          if (miss) begin
            state <= ST_FLUSH;
            fcnt  <= FC_W'(FLUSH_CYCLES - 1);
            flush <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (fcnt == '0) begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end else begin
            fcnt <= fcnt - FC_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics: hold at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (pop  && branch_count     != '1) branch_count     <= branch_count + CNT_W'(1);
      if (miss && mispredict_count != '1) mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             d_valid, d_pred, e_valid, e_taken;
  logic [PC_W-1:0]  d_pc, d_target, e_pc;
  logic             d_stall, update_enable, update_value, mispredict, flush, seq_error, full, empty;
  logic [PC_W-1:0]  update_pc, redirect_pc;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  int n_assert = 0;
  int n_fail   = 0;

  branch_resolver #(.PC_W(PC_W), .DEPTH(4), .CNT_W(CNT_W), .FLUSH_CYCLES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .d_valid          (d_valid),
    .d_pc             (d_pc),
    .d_pred           (d_pred),
    .d_target         (d_target),
    .d_stall          (d_stall),
    .e_valid          (e_valid),
    .e_pc             (e_pc),
    .e_taken          (e_taken),
    .update_enable    (update_enable),
    .update_value     (update_value),
    .update_pc        (update_pc),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .seq_error        (seq_error),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
    .full             (full),
    .empty            (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input logic pred, input logic [PC_W-1:0] tgt);
    d_valid = 1'b1; d_pc = pc; d_pred = pred; d_target = tgt;
  endtask

  task automatic resolve(input logic [PC_W-1:0] pc, input logic taken);
    e_valid = 1'b1; e_pc = pc; e_taken = taken;
  endtask

  task automatic idle_in();
    d_valid = 1'b0; e_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    d_valid = 0; d_pc = '0; d_pred = 0; d_target = '0;
    e_valid = 0; e_pc = '0; e_taken = 0;
    #3;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_upd", 32'(update_enable), 32'd0);
    check("rst_bcnt", 32'(branch_count), 32'd0);
    tick();
    rst = 1'b0;

    // Correct prediction
    push(10'h010, 1'b1, 10'h020);
    tick();
    idle_in();
    check("t1_not_empty", 32'(empty), 32'd0);
    resolve(10'h010, 1'b1);
    tick();
    idle_in();
    check("t1_upd_en", 32'(update_enable), 32'd1);
    check("t1_upd_val", 32'(update_value), 32'd1);
    check("t1_upd_pc", 32'(update_pc), 32'h010);
    check("t1_misp", 32'(mispredict), 32'd0);
    check("t1_flush", 32'(flush), 32'd0);
    check("t1_bcnt", 32'(branch_count), 32'd1);
    check("t1_empty", 32'(empty), 32'd1);
    tick();
    check("t1_upd_pulse", 32'(update_enable), 32'd0);

    // Not-taken mispredict with PC wrap
    push(10'h3FF, 1'b1, 10'h100);
    tick();
    idle_in();
    resolve(10'h3FF, 1'b0);
    tick();
    idle_in();
    check("t2_misp", 32'(mispredict), 32'd1);
    check("t2_redirect", 32'(redirect_pc), 32'h000);
    check("t2_flush0", 32'(flush), 32'd1);
    check("t2_mcnt", 32'(mispredict_count), 32'd1);
    check("t2_upd_val", 32'(update_value), 32'd0);
    check("t2_bcnt", 32'(branch_count), 32'd2);
    tick();
    check("t2_misp_pulse", 32'(mispredict), 32'd0);
    check("t2_flush1", 32'(flush), 32'd1);
    tick();
    check("t2_flush_end", 32'(flush), 32'd0);

    // Full queue and younger-entry discard
    push(10'h040, 1'b0, 10'h155); tick();
    push(10'h041, 1'b0, 10'h0AA); tick();
    push(10'h042, 1'b0, 10'h0AB); tick();
    push(10'h043, 1'b0, 10'h0AC); tick();
    push(10'h044, 1'b0, 10'h0AD);
    #1;
    check("t3_full", 32'(full), 32'd1);
    check("t3_stall", 32'(d_stall), 32'd1);
    resolve(10'h040, 1'b1);
    tick();
    check("t3_misp", 32'(mispredict), 32'd1);
    check("t3_redirect", 32'(redirect_pc), 32'h155);
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_flush", 32'(flush), 32'd1);
    push(10'h050, 1'b1, 10'h000);
    resolve(10'h050, 1'b1);
    tick();
    check("t3_drop_upd0", 32'(update_enable), 32'd0);
    check("t3_drop_empty0", 32'(empty), 32'd1);
    tick();
    idle_in();
    check("t3_drop_upd1", 32'(update_enable), 32'd0);
    check("t3_drop_empty1", 32'(empty), 32'd1);
    check("t3_flush_end", 32'(flush), 32'd0);
    check("t3_seq_err", 32'(seq_error), 32'd0);
    check("t3_bcnt", 32'(branch_count), 32'd3);
    check("t3_mcnt", 32'(mispredict_count), 32'd2);

    // Simultaneous push and pop with two entries queued
    push(10'h060, 1'b1, 10'h070); tick();
    push(10'h061, 1'b1, 10'h071); tick();
    push(10'h062, 1'b1, 10'h072);
    resolve(10'h060, 1'b1);
    tick();
    idle_in();
    check("t4_upd_pc0", 32'(update_pc), 32'h060);
    check("t4_full", 32'(full), 32'd0);
    check("t4_not_empty", 32'(empty), 32'd0);
    resolve(10'h061, 1'b1);
    tick();
    idle_in();
    check("t4_upd_pc1", 32'(update_pc), 32'h061);
    check("t4_not_empty1", 32'(empty), 32'd0);
    resolve(10'h062, 1'b1);
    tick();
    idle_in();
    check("t4_upd_pc2", 32'(update_pc), 32'h062);
    check("t4_upd_en2", 32'(update_enable), 32'd1);
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_seq_err", 32'(seq_error), 32'd0);
    check("t4_bcnt", 32'(branch_count), 32'd6);

    // Protocol errors
    resolve(10'h004, 1'b0);
    tick();
    idle_in();
    check("t5_no_upd", 32'(update_enable), 32'd0);
    check("t5_seq_err", 32'(seq_error), 32'd1);
    check("t5_bcnt", 32'(branch_count), 32'd6);
    push(10'h004, 1'b0, 10'h00C);
    tick();
    idle_in();
    resolve(10'h008, 1'b0);
    tick();
    idle_in();
    check("t5_upd_en", 32'(update_enable), 32'd1);
    check("t5_upd_pc", 32'(update_pc), 32'h008);
    check("t5_misp", 32'(mispredict), 32'd0);
    check("t5_bcnt2", 32'(branch_count), 32'd7);
    tick();
    check("t5_sticky", 32'(seq_error), 32'd1);

    // Reset in the first flush cycle
    push(10'h0F0, 1'b0, 10'h0AA);
    tick();
    idle_in();
    resolve(10'h0F0, 1'b1);
    tick();
    idle_in();
    check("t6_flush_pre", 32'(flush), 32'd1);
    check("t6_misp_pre", 32'(mispredict), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_flush", 32'(flush), 32'd0);
    check("t6_misp", 32'(mispredict), 32'd0);
    check("t6_upd", 32'(update_enable), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_bcnt", 32'(branch_count), 32'd0);
    check("t6_mcnt", 32'(mispredict_count), 32'd0);
    check("t6_seq_err", 32'(seq_error), 32'd0);
    rst = 1'b0;
    push(10'h0B0, 1'b1, 10'h0C0);
    tick();
    idle_in();
    check("t6_push_after", 32'(empty), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-stage counterpart to the tournament branch predictor.
- Holds in-flight Decode-stage predictions in a small ordered queue and checks each against the actual outcome resolved in Execute.
- Drives the predictor's update interface (update_enable/update_value), and on a mispredict issues redirect_pc plus a multi-cycle pipeline flush.
- Keeps saturating branch and mispredict statistics.

Parameters:
- PC_W, 10, width of word-addressed PC; matches predictor pc_D/pc_E.
- DEPTH, 4, in-flight prediction queue entries; power of two, at least 2.
- CNT_W, 16, width of statistics counters.
- FLUSH_CYCLES, 2, cycles flush stays asserted after a mispredict; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- d_valid  in  1  Decode holds a branch with a prediction this cycle.
- d_pc  in  PC_W  PC of that branch.
- d_pred  in  1  predictor output for that branch (1 = taken).
- d_target  in  PC_W  taken-target of that branch.
- d_stall  out  1  queue full; Decode must hold the branch. Combinational: d_valid & full.
- e_valid  in  1  Execute resolves a branch this cycle.
- e_pc  in  PC_W  PC of the resolved branch.
- e_taken  in  1  actual outcome.
- update_enable  out  1  predictor update strobe.
- update_value  out  1  actual outcome to train with.
- update_pc  out  PC_W  PC being trained.
- mispredict  out  1  one-cycle pulse.
- redirect_pc  out  PC_W  corrected fetch PC; valid while mispredict = 1.
- flush  out  1  kill younger Fetch/Decode instructions.
- seq_error  out  1  sticky; set when a resolve arrives on an empty queue or with e_pc != head pc.
- branch_count  out  CNT_W  resolved branches, saturating.
- mispredict_count  out  CNT_W  mispredicts, saturating.
- full, empty  out  1  queue status.

Behaviour:
- Reset (async, any time including mid-flush): queue empty, FSM IDLE. All outputs 0 except empty = 1. Counters 0, seq_error 0.
- Queue entry holds {pc, pred, target}. Write and read pointers are PC-width independent and wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.
- Push: d_valid & !full & state == IDLE. In the FLUSH state, pushes are dropped because the instructions are being killed.
- Pop: e_valid & !empty. Push and pop in the same cycle are both performed; the occupancy count is unchanged.
- Resolve with pop, registered with 1-cycle latency:
  - update_enable = 1, update_value = e_taken, update_pc = head.pc.
  - branch_count increments.
  - If head.pc != e_pc, seq_error is set, but the update is still issued using e_pc.
- Resolve when empty: no update, seq_error set, counters unchanged.
- Mispredict when e_taken != head.pred, registered in the same cycle as the update:
  - mispredict = 1 for 1 cycle.
  - redirect_pc = head.target if e_taken, else head.pc + 1, truncated to PC_W (wraps from all-ones to 0).
  - mispredict_count increments.
  - Queue cleared: all younger entries discarded, and a same-cycle push is also discarded.
  - FSM moves IDLE -> FLUSH.
- FSM:
  - IDLE: flush = 0.
  - FLUSH: flush = 1. A down-counter loaded with FLUSH_CYCLES-1 on entry runs down; the FSM returns to IDLE after it reaches 0. flush is high for exactly FLUSH_CYCLES cycles, starting in the same cycle as mispredict.
  - e_valid during FLUSH is ignored: no update, no error.
- Counters hold at all-ones and do not wrap.
- Outputs update_enable and mispredict are pulses. They are low in any cycle without a qualifying resolve.

Decomposition:
- Shared package branch_pkg: PC_W default, the FSM state encoding (IDLE, FLUSH), and a typedef for the queue entry struct. The predictor adopts the same PC_W.
- One sub-module, pred_queue: a parameterised synchronous FIFO with clear, full, and empty signals.
- FSM, compare logic and counters stay in branch_resolver.

Test Plan:
- Correct prediction:
  - Stimulus: push pc=0x010, pred=1, target=0x020; next cycle resolve e_pc=0x010, e_taken=1.
  - Required: one cycle later update_enable=1, update_value=1, update_pc=0x010; mispredict=0, flush=0; branch_count=1; empty=1.
- Not-taken mispredict with wrap:
  - Stimulus: push pc=0x3FF, pred=1; resolve e_taken=0.
  - Required: mispredict pulse, redirect_pc=0x000, flush high exactly 2 cycles, mispredict_count=1.
- Full queue and younger-entry discard:
  - Stimulus: push 4 branches, then d_valid again; resolve the first as a mispredict (pred=0, taken=1, target=0x155).
  - Required: d_stall=1 while full; redirect_pc=0x155; empty=1 afterwards; pushes during flush are dropped and update_enable stays 0 for them.
- Simultaneous push and pop with 2 entries queued:
  - Required: occupancy stays 2, FIFO order is preserved, and 3 subsequent resolves train PCs in push order.
- Protocol errors:
  - Stimulus: resolve on an empty queue; then push pc=0x004 and resolve with e_pc=0x008.
  - Required: no update for the first resolve; seq_error=1 and stays set; the second update uses update_pc=0x008.
- Reset mid-flush:
  - Stimulus: assert rst asynchronously in the first flush cycle.
  - Required: flush, mispredict, and update_enable drop immediately; empty=1, counters=0, seq_error=0. After release, a push is accepted on the next clock.
